ws2812_rx: RTL and testbench

WS2812_RX -- requirements
Module: ws2812_rx

---
 rtl/ws2812_pkg.sv | 45 ++++
 rtl/ws2812_rx_din_sync.sv | 38 +++
 rtl/ws2812_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions for the receiver and the existing transmitter.
// Holds clock-derived pulse timing constants (in clocks) and the receiver
// FSM state encoding.
package ws2812_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 12000000;

    // Truncating conversion of a duration in ns to whole clock periods.
    function automatic int unsigned ns_to_clks(input int unsigned clk_hz,
                                               input int unsigned ns);
        longint unsigned prod;
        prod = longint'(clk_hz) * longint'(ns);
        return int'(prod / 64'd1000000000);
    endfunction

    function automatic int unsigned t0h_clks(input int unsigned clk_hz);
        return ns_to_clks(clk_hz, 350);
    endfunction

    function automatic int unsigned t1h_clks(input int unsigned clk_hz);
        return ns_to_clks(clk_hz, 700);
    endfunction

    // Decision point between the 0 and 1 high times.
    function automatic int unsigned bit_thresh_clks(input int unsigned clk_hz);
        return ns_to_clks(clk_hz, 600);
    endfunction

    // 50 us reset/latch low time.
    function automatic int unsigned latch_clks(input int unsigned clk_hz);
        return ns_to_clks(clk_hz, 50000);
    endfunction

    localparam int unsigned T0H          = t0h_clks(DEFAULT_CLK_HZ);
    localparam int unsigned T1H          = t1h_clks(DEFAULT_CLK_HZ);
    localparam int unsigned BIT_THRESH   = bit_thresh_clks(DEFAULT_CLK_HZ);
    localparam int unsigned LATCH_CYCLES = latch_clks(DEFAULT_CLK_HZ);

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        IDLE_LOW   = 2'd1,
        HIGH       = 2'd2
    } ws_state_t;

endpackage

// File: rtl/ws2812_rx_din_sync.sv
// din_sync: two-flop synchronizer for the asynchronous WS2812 data line plus
// edge detection on the synchronized level.
//   CLK   system clock
//   RST   synchronous active-high reset
//   DIN   asynchronous serial data line
//   din_s synchronized level (2 clocks behind DIN)
//   rise  one-cycle pulse on the first synchronized high cycle
//   fall  one-cycle pulse on the first synchronized low cycle
module din_sync (
    input  logic CLK,
    input  logic RST,
    input  logic DIN,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= DIN;
            sync <= meta;
            prev <= sync;
        end
    end

    assign din_s = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 serial pixel receiver.
// Measures each high pulse on DIN, classifies it as 0/1 bit (or glitch /
// overlong error), assembles 24-bit GRB words and presents them as RGB with
// their frame position. A long low gap ends the frame.
//   CLK          system clock
//   RST          synchronous active-high reset
//   DIN          asynchronous WS2812 data line
//   r/g/b_value  colour bytes of the last pixel received (held)
//   pixel_index  frame position of the pixel on r/g/b_value
//   pixel_valid  one-cycle strobe qualifying r/g/b_value and pixel_index
//   frame_done   one-cycle strobe on each detected latch gap
//   error        sticky: glitch, overlong high or partial pixel
//   overflow     sticky: more than MAX_PIXELS pixels in one frame
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int unsigned BIT_THRESH   = bit_thresh_clks(CLK_HZ),
    parameter int unsigned MIN_HIGH     = 2,
    parameter int unsigned MAX_HIGH     = 18,
    parameter int unsigned LATCH_CYCLES = latch_clks(CLK_HZ),
    parameter int unsigned MAX_PIXELS   = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DIN,
    output logic [7:0] r_value,
    output logic [7:0] g_value,
    output logic [7:0] b_value,
    output logic [3:0] pixel_index,
    output logic       pixel_valid,
    output logic       frame_done,
    output logic       error,
    output logic       overflow
);

    localparam int unsigned LW = $clog2(LATCH_CYCLES + 1);
    localparam int unsigned HW = $clog2(MAX_HIGH + 2);

    localparam logic [LW-1:0] LATCH_END = LW'(LATCH_CYCLES);
    localparam logic [LW-1:0] LATCH_PRE = LW'(LATCH_CYCLES - 1);
    localparam logic [HW-1:0] HIGH_SAT  = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0] HIGH_MIN  = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HIGH_THR  = HW'(BIT_THRESH);
    localparam logic [3:0]    LAST_IDX  = 4'(MAX_PIXELS - 1);

    logic din_s;
    logic rise;
    logic fall;

    din_sync u_din_sync (
        .CLK   (CLK),
        .RST   (RST),
        .DIN   (DIN),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    ws_state_t     state;
    ws_state_t     state_n;
    logic [LW-1:0] low_cnt;
    logic [HW-1:0] high_cnt;
    logic [23:0]   shift;
    logic [4:0]    bit_cnt;
    logic [3:0]    pix_idx;
    logic          pix_full;   // MAX_PIXELS already delivered this frame
    logic          pix_load;   // complete word sitting in shift
    logic          frame_err;  // error raised since the frame started
    logic          frame_ovf;  // overflow raised since the frame started

    logic take_bit;
    logic bit_val;
    logic glitch;
    logic timeout;
    logic frame_end;
    logic frame_start;

    always_comb begin
        state_n     = state;
        take_bit    = 1'b0;
        bit_val     = 1'b0;
        glitch      = 1'b0;
        timeout     = 1'b0;
        frame_end   = 1'b0;
        frame_start = 1'b0;
        case (state)
            WAIT_LATCH: begin
                if (!rise && low_cnt == LATCH_END) begin
                    state_n     = IDLE_LOW;
                    frame_start = 1'b1;
                end
            end
            IDLE_LOW: begin
                if (rise) begin
                    state_n = HIGH;
                end else if (!din_s && low_cnt == LATCH_PRE) begin
                    // Counter reaches LATCH_CYCLES on this edge and then
                    // saturates, so this fires once per gap.
                    frame_end = 1'b1;
                end
            end
            HIGH: begin
                // Saturation is checked before the falling edge so a high of
                // exactly MAX_HIGH+1 clocks is rejected.
                if (high_cnt == HIGH_SAT) begin
                    timeout = 1'b1;
                    state_n = WAIT_LATCH;
                end else if (fall) begin
                    state_n = IDLE_LOW;
                    if (high_cnt < HIGH_MIN) begin
                        glitch = 1'b1;
                    end else begin
                        take_bit = 1'b1;
                        bit_val  = (high_cnt >= HIGH_THR);
                    end
                end
            end
            default: state_n = WAIT_LATCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= WAIT_LATCH;
            low_cnt     <= '0;
            high_cnt    <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            pix_idx     <= '0;
            pix_full    <= 1'b0;
            pix_load    <= 1'b0;
            frame_err   <= 1'b0;
            frame_ovf   <= 1'b0;
            r_value     <= '0;
            g_value     <= '0;
            b_value     <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            pix_load    <= 1'b0;

            if (din_s) begin
                low_cnt <= '0;
            end else if (low_cnt != LATCH_END) begin
                low_cnt <= low_cnt + LW'(1);
            end

            if (state == IDLE_LOW && rise) begin
                high_cnt <= HW'(1);
            end else if (state == HIGH && din_s && high_cnt != HIGH_SAT) begin
                high_cnt <= high_cnt + HW'(1);
            end

            if (glitch || timeout) begin
                error     <= 1'b1;
                frame_err <= 1'b1;
            end

            if (timeout) begin
                shift    <= '0;
                bit_cnt  <= '0;
                pix_idx  <= '0;
                pix_full <= 1'b0;
            end

            if (frame_start) begin
                frame_err <= 1'b0;
                frame_ovf <= 1'b0;
            end

            if (take_bit) begin
                shift <= {shift[22:0], bit_val};
                if (bit_cnt == 5'd23) begin
                    bit_cnt  <= '0;
                    pix_load <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end

            // Word is unpacked one clock after its last bit; wire order GRB.
            if (pix_load) begin
                g_value     <= shift[23:16];
                r_value     <= shift[15:8];
                b_value     <= shift[7:0];
                pixel_index <= pix_idx;
                pixel_valid <= 1'b1;
                if (pix_full) begin
                    overflow  <= 1'b1;
                    frame_ovf <= 1'b1;
                end else if (pix_idx == LAST_IDX) begin
                    pix_full <= 1'b1;
                end else begin
                    pix_idx <= pix_idx + 4'd1;
                end
            end

            if (frame_end) begin
                frame_done <= 1'b1;
                pix_idx    <= '0;
                pix_full   <= 1'b0;
                frame_err  <= 1'b0;
                frame_ovf  <= 1'b0;
                if (bit_cnt != 5'd0) begin
                    error   <= 1'b1;
                    bit_cnt <= '0;
                    shift   <= '0;
                end else if (!frame_err && !frame_ovf) begin
                    error    <= 1'b0;
                    overflow <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: directed frame sequence with randomized
// pixel data and pulse widths, compared against a frame-level reference model.
module tb_ws2812_rx;

    localparam int MAXP = 10;
    localparam int GAP  = 630;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DIN;
    logic [7:0] r_value;
    logic [7:0] g_value;
    logic [7:0] b_value;
    logic [3:0] pixel_index;
    logic       pixel_valid;
    logic       frame_done;
    logic       error;
    logic       overflow;

    ws2812_rx #(
        .CLK_HZ       (12000000),
        .BIT_THRESH   (7),
        .MIN_HIGH     (2),
        .MAX_HIGH     (18),
        .LATCH_CYCLES (600),
        .MAX_PIXELS   (MAXP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .DIN         (DIN),
        .r_value     (r_value),
        .g_value     (g_value),
        .b_value     (b_value),
        .pixel_index (pixel_index),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .error       (error),
        .overflow    (overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    pix_t got_q[$];
    pix_t sent_q[$];
    int   fd_cnt   = 0;
    int   both_cnt = 0;
    int   tests    = 0;
    int   fails    = 0;

    // Reference model state
    logic m_err  = 1'b0;
    logic m_ovf  = 1'b0;
    int   nbits  = 0;
    logic fault  = 1'b0;

    always @(negedge CLK) begin
        pix_t p;
        if (pixel_valid) begin
            p = {pixel_index, r_value, g_value, b_value};
            got_q.push_back(p);
        end
        if (frame_done) fd_cnt++;
        if (pixel_valid && frame_done) both_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        DIN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // mode 0: random legal widths, 1: 4/8 highs on 15-clock periods,
    // 2: extreme legal highs (MIN_HIGH for 0, MAX_HIGH for 1)
    task automatic send_bit(input logic b, input int mode);
        int hi;
        int lo;
        if (mode == 1) begin
            hi = b ? 8 : 4;
            lo = 15 - hi;
        end else if (mode == 2) begin
            hi = b ? 18 : 2;
            lo = 3;
        end else begin
            hi = b ? int'($urandom_range(18, 7)) : int'($urandom_range(6, 2));
            lo = int'($urandom_range(10, 3));
        end
        drive(1'b1, hi);
        drive(1'b0, lo);
        nbits++;
    endtask

    task automatic send_pixel(input logic [7:0] g, input logic [7:0] r,
                              input logic [7:0] b, input int mode, input int glitch_at);
        logic [23:0] w;
        w = {g, r, b};
        for (int i = 23; i >= 0; i--) begin
            if (i == glitch_at) begin
                drive(1'b1, 1);
                drive(1'b0, 3);
            end
            send_bit(w[i], mode);
        end
    endtask

    task automatic frame_px(input logic [7:0] g, input logic [7:0] r,
                            input logic [7:0] b, input int mode, input int glitch_at);
        pix_t p;
        p = {4'd0, r, g, b};
        sent_q.push_back(p);
        send_pixel(g, r, b, mode, glitch_at);
    endtask

    task automatic rand_px(input int mode);
        frame_px(8'($urandom), 8'($urandom), 8'($urandom), mode, -1);
    endtask

    // Ends a frame with a latch gap, applies the frame rules to the model and
    // compares every delivered pixel and the sticky flags.
    task automatic close_frame(input string tag);
        int   fd0;
        int   n;
        logic partial;
        pix_t e;
        fd0 = fd_cnt;
        drive(1'b0, GAP);
        n       = sent_q.size();
        partial = (nbits % 24) != 0;
        if (n > MAXP) m_ovf = 1'b1;
        if (fault) m_err = 1'b1;
        if (partial) m_err = 1'b1;
        else if (!fault && n <= MAXP) begin
            m_err = 1'b0;
            m_ovf = 1'b0;
        end
        check({tag, " count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                e     = sent_q[i];
                e.idx = (i < MAXP) ? 4'(i) : 4'(MAXP - 1);
                check($sformatf("%s px%0d", tag, i), {4'd0, got_q[i]}, {4'd0, e});
            end
        end
        check({tag, " frame_done"}, 32'(fd_cnt - fd0), 32'd1);
        check({tag, " error"}, 32'(error), 32'(m_err));
        check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        got_q.delete();
        sent_q.delete();
        nbits = 0;
        fault = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        DIN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        check("rst r", 32'(r_value), 32'd0);
        check("rst g", 32'(g_value), 32'd0);
        check("rst b", 32'(b_value), 32'd0);
        check("rst idx", 32'(pixel_index), 32'd0);
        check("rst valid", 32'(pixel_valid), 32'd0);
        check("rst done", 32'(frame_done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);

        // Basic pixel with nominal timing
        drive(1'b0, GAP);
        frame_px(8'h40, 8'hFF, 8'h00, 1, -1);
        close_frame("basic");

        // Full frame r=index g=0 b=0x80
        for (int i = 0; i < MAXP; i++) frame_px(8'h00, 8'(i), 8'h80, 0, -1);
        close_frame("full");

        // Overflow frame, then a clean single-pixel frame clears it
        for (int i = 0; i < MAXP + 1; i++) rand_px(0);
        close_frame("ovf");
        rand_px(0);
        close_frame("ovf_clear");

        // Random frame lengths around the pixel limit
        for (int f = 0; f < 2; f++) begin
            int n;
            n = int'($urandom_range(MAXP + 2, 1));
            for (int i = 0; i < n; i++) rand_px(0);
            close_frame($sformatf("rand%0d", f));
        end
        rand_px(0);
        close_frame("rand_clean");

        // Extreme legal high widths
        rand_px(2);
        rand_px(2);
        close_frame("extreme");

        // Partial pixel: 12 bits then latch gap
        for (int i = 0; i < 12; i++) send_bit(1'($urandom), 0);
        close_frame("partial");
        rand_px(0);
        close_frame("partial_clear");

        // Short glitch mid-pixel is discarded but flags error for the frame
        fault = 1'b1;
        frame_px(8'($urandom), 8'($urandom), 8'($urandom), 0, 11);
        close_frame("glitch");
        rand_px(0);
        close_frame("glitch_clear");

        // Overlong high aborts; data without a latch gap is ignored
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 0);
        drive(1'b1, 25);
        drive(1'b0, 5);
        m_err = 1'b1;
        nbits = 0;
        send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 0, -1);
        drive(1'b0, GAP);
        check("long_high no pixel", 32'(got_q.size()), 32'd0);
        check("long_high error", 32'(error), 32'd1);
        got_q.delete();
        nbits = 0;
        rand_px(0);
        close_frame("after_long");

        // Reset mid-pixel
        for (int i = 0; i < 16; i++) send_bit(1'($urandom), 0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_err = 1'b0;
        m_ovf = 1'b0;
        check("midrst r", 32'(r_value), 32'd0);
        check("midrst g", 32'(g_value), 32'd0);
        check("midrst b", 32'(b_value), 32'd0);
        check("midrst idx", 32'(pixel_index), 32'd0);
        check("midrst error", 32'(error), 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 0);
        send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 0, -1);
        drive(1'b0, GAP);
        check("midrst ignored", 32'(got_q.size()), 32'd0);
        got_q.delete();
        nbits = 0;
        rand_px(0);
        close_frame("after_rst");

        check("valid_done overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
